// File: rtl/gpu_cmd_seq.sv
// gpu_cmd_seq: queues {opcode, parameter} command pairs from a requester and
// streams them to a GPU command input as a CW, PW, EX word triplet. When no
// command is pending it alternates idle phases A and B.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   clr       asynchronous active-high reset
//   in_valid  requester presents a command/param pair
//   in_cmd    opcode word (legal range 16'h00C0..16'h00C6)
//   in_param  parameter word
//   in_ready  FIFO has room (count < DEPTH), independent of a same-cycle pop
//   flush     synchronous discard of all queued entries
//   cpuline   registered word stream to the GPU
//   bad_cmd   registered one-cycle pulse for an accepted-but-illegal opcode
//   busy      entries queued or a CW/PW/EX triplet in flight
//   level     current FIFO count
//
// DEPTH must be a power of two and at least 2; pointers wrap naturally.
module gpu_cmd_seq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [15:0]            in_cmd,
    input  logic [15:0]            in_param,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [15:0]            cpuline,
    output logic                   bad_cmd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] FULL_CNT = LW'(DEPTH);

    // The state names the GPU slot of the word currently on cpuline.
    typedef enum logic [2:0] {
        StIa,
        StIb,
        StCw,
        StPw,
        StEx
    } state_t;

    state_t        r_state;
    logic [15:0]   r_cpuline;
    logic [15:0]   r_param;
    logic          r_bad;

    logic [15:0]   r_mem_cmd [DEPTH];
    logic [15:0]   r_mem_par [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_legal;
    logic          w_accept;
    logic          w_push;
    logic          w_bad;
    logic          w_decide;
    logic          w_pop;

    assign in_ready = (r_count < FULL_CNT);
    assign w_legal  = (in_cmd >= 16'h00C0) && (in_cmd <= 16'h00C6);
    assign w_accept = in_valid && in_ready;
    // Flush wins over a same-cycle push; an illegal opcode is still reported.
    assign w_push   = w_accept && w_legal && !flush;
    assign w_bad    = w_accept && !w_legal;

    // Only the IB and EX slots decide what comes next. The decision looks at
    // the registered count, so a same-cycle push into an empty FIFO waits.
    assign w_decide = (r_state == StIb) || (r_state == StEx);
    assign w_pop    = w_decide && (r_count != '0) && !flush;

    assign cpuline  = r_cpuline;
    assign bad_cmd  = r_bad;
    assign level    = r_count;
    assign busy     = (r_count != '0) || (r_state == StCw) || (r_state == StPw) ||
                      (r_state == StEx);

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cmd[r_wr_ptr] <= in_cmd;
            r_mem_par[r_wr_ptr] <= in_param;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer with registered word output. An in-flight triplet always
    // completes; flush only affects the IB/EX decision through w_pop.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= StIa;
            r_cpuline <= '0;
            r_param   <= '0;
            r_bad     <= 1'b0;
        end else begin
            r_bad <= w_bad;
            case (r_state)
                StIa: begin
                    r_state   <= StIb;
                    r_cpuline <= '0;
                end
                StIb, StEx: begin
                    if (w_pop) begin
                        r_state   <= StCw;
                        r_cpuline <= r_mem_cmd[r_rd_ptr];
                        r_param   <= r_mem_par[r_rd_ptr];
                    end else begin
                        r_state   <= StIa;
                        r_cpuline <= '0;
                    end
                end
                StCw: begin
                    r_state   <= StPw;
                    r_cpuline <= r_param;
                end
                StPw: begin
                    r_state   <= StEx;
                    r_cpuline <= '0;
                end
                default: begin
                    r_state   <= StIa;
                    r_cpuline <= '0;
                end
            endcase
        end
    end

endmodule
